// File: rtl/ibex_avalon_bridge.sv
// Ibex LSU data port to Avalon-MM master bridge with an in-order response tracker.
// Define IBEX_AVL_WRESP_EN to complete writes on avm_writeresponsevalid_i instead of at acceptance.
module ibex_avalon_bridge #(
    parameter int MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        avm_read_o,
    output logic        avm_write_o,
    output logic [31:0] avm_address_o,
    output logic [3:0]  avm_byteenable_o,
    output logic [31:0] avm_writedata_o,
    input  logic        avm_waitrequest_i,
    input  logic [31:0] avm_readdata_i,
    input  logic        avm_readdatavalid_i,
    input  logic [1:0]  avm_response_i,
    input  logic        avm_writeresponsevalid_i,
    output logic        protocol_err_o
);
    localparam logic [1:0] LastPtr = 2'(MaxOutstanding - 1);
    localparam logic [2:0] MaxCnt  = 3'(MaxOutstanding);

    logic        r_cmd_valid;
    logic        r_cmd_we;
    logic [3:0]  r_cmd_be;
    logic [31:0] r_cmd_addr;
    logic [31:0] r_cmd_wdata;
    logic [3:0]  r_fifo;
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_fcount;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_perr;

    logic        w_accept;
    logic        w_head_valid;
    logic        w_head_we;
    logic        w_pop_rd;
    logic        w_pop_wr;
    logic        w_pop;
    logic        w_bad_rsp;
    logic        w_rsp_err;
    logic        w_gnt;
    logic [2:0]  w_out_after;

    assign w_accept     = r_cmd_valid & ~avm_waitrequest_i;
    assign w_head_valid = (r_fcount != 3'd0);
    assign w_head_we    = r_fifo[r_rptr];
    assign w_pop_rd     = avm_readdatavalid_i & w_head_valid & ~w_head_we;

`ifdef IBEX_AVL_WRESP_EN
    assign w_pop_wr  = avm_writeresponsevalid_i & w_head_valid & w_head_we;
    assign w_bad_rsp = (avm_readdatavalid_i & ~w_pop_rd)
                     | (avm_writeresponsevalid_i & ~w_pop_wr)
                     | (avm_readdatavalid_i & avm_writeresponsevalid_i);
    assign w_rsp_err = (avm_response_i != 2'b00);
`else
    // A write entering an empty tracker is already at the head, so it completes in its acceptance cycle.
    logic w_unused_wresp;
    assign w_unused_wresp = avm_writeresponsevalid_i;
    assign w_pop_wr  = w_head_valid ? w_head_we : (w_accept & r_cmd_we);
    assign w_bad_rsp = avm_readdatavalid_i & ~w_pop_rd;
    assign w_rsp_err = w_pop_rd & (avm_response_i != 2'b00);
`endif

    assign w_pop       = w_pop_rd | w_pop_wr;
    assign w_out_after = {2'b00, r_cmd_valid} + r_fcount - {2'b00, w_pop};
    assign w_gnt       = rst_ni & data_req_i & (~r_cmd_valid | w_accept) & (w_out_after < MaxCnt);

    assign data_gnt_o       = w_gnt;
    assign data_rvalid_o    = r_rvalid;
    assign data_rdata_o     = r_rdata;
    assign data_err_o       = r_err;
    assign avm_read_o       = r_cmd_valid & ~r_cmd_we;
    assign avm_write_o      = r_cmd_valid & r_cmd_we;
    assign avm_address_o    = r_cmd_addr;
    assign avm_byteenable_o = r_cmd_be;
    assign avm_writedata_o  = r_cmd_wdata;
    assign protocol_err_o   = r_perr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cmd_valid <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_be    <= 4'd0;
            r_cmd_addr  <= 32'd0;
            r_cmd_wdata <= 32'd0;
            r_fifo      <= 4'd0;
            r_wptr      <= 2'd0;
            r_rptr      <= 2'd0;
            r_fcount    <= 3'd0;
            r_rvalid    <= 1'b0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
            r_perr      <= 1'b0;
        end else begin
            if (w_gnt) begin
                r_cmd_valid <= 1'b1;
                r_cmd_we    <= data_we_i;
                r_cmd_be    <= data_be_i;
                r_cmd_addr  <= data_addr_i;
                r_cmd_wdata <= data_wdata_i;
            end else if (w_accept) begin
                r_cmd_valid <= 1'b0;
            end

            if (w_accept) begin
                r_fifo[r_wptr] <= r_cmd_we;
                r_wptr         <= (r_wptr == LastPtr) ? 2'd0 : r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LastPtr) ? 2'd0 : r_rptr + 2'd1;
            end

            case ({w_accept, w_pop})
                2'b10:   r_fcount <= r_fcount + 3'd1;
                2'b01:   r_fcount <= r_fcount - 3'd1;
                default: r_fcount <= r_fcount;
            endcase

            r_rvalid <= w_pop;
            r_rdata  <= w_pop_rd ? avm_readdata_i : 32'd0;
            r_err    <= w_pop & w_rsp_err;
            if (w_bad_rsp) begin
                r_perr <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ibex_avalon_bridge.sv
// Self-checking bench for ibex_avalon_bridge: directed protocol cases, then random traffic
// against an in-order response scoreboard and an Avalon slave model.
`timescale 1ns/1ps
module tb_ibex_avalon_bridge;
    localparam int W = 33;
`ifdef IBEX_AVL_WRESP_EN
    localparam bit WrespEn = 1'b1;
`else
    localparam bit WrespEn = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        avm_read_o, avm_write_o, avm_waitrequest_i, avm_readdatavalid_i;
    logic        avm_writeresponsevalid_i, protocol_err_o;
    logic [31:0] avm_address_o, avm_writedata_o, avm_readdata_i;
    logic [3:0]  avm_byteenable_o;
    logic [1:0]  avm_response_i;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } plan_t;
    typedef struct packed {
        logic        we;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] ready;
    } pend_t;

    int          checks = 0;
    int          failures = 0;
    logic [W-1:0] exp_q[$];
    cmd_t        cmd_q[$];
    plan_t       plan_q[$];
    pend_t       pend_q[$];
    cmd_t        cur, c;
    plan_t       p;
    pend_t       pe;
    logic [31:0] cyc;
    logic [31:0] d1, d2, d3, wd;
    bit          granted;

    always #5 clk_i = ~clk_i;

    ibex_avalon_bridge #(.MaxOutstanding(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .avm_read_o(avm_read_o), .avm_write_o(avm_write_o), .avm_address_o(avm_address_o),
        .avm_byteenable_o(avm_byteenable_o), .avm_writedata_o(avm_writedata_o),
        .avm_waitrequest_i(avm_waitrequest_i), .avm_readdata_i(avm_readdata_i),
        .avm_readdatavalid_i(avm_readdatavalid_i), .avm_response_i(avm_response_i),
        .avm_writeresponsevalid_i(avm_writeresponsevalid_i), .protocol_err_o(protocol_err_o)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
        data_addr_i = 32'h0; data_wdata_i = 32'h0;
        avm_waitrequest_i = 1'b0; avm_readdata_i = 32'h0; avm_readdatavalid_i = 1'b0;
        avm_response_i = 2'b00; avm_writeresponsevalid_i = 1'b0;
    endtask

    task automatic drive_req(input cmd_t r);
        data_req_i = 1'b1; data_we_i = r.we; data_be_i = r.be;
        data_addr_i = r.addr; data_wdata_i = r.wdata;
    endtask

    // Response the core must see for a granted transaction, in issue order.
    task automatic expect_push(input logic we, input logic [31:0] data, input logic [1:0] resp);
        if (we) exp_q.push_back({WrespEn && (resp != 2'b00), 32'h0});
        else    exp_q.push_back({resp != 2'b00, data});
    endtask

    function automatic logic [127:0] all_outputs();
        return {data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o, avm_read_o, avm_write_o,
                avm_address_o, avm_byteenable_o, avm_writedata_o, protocol_err_o};
    endfunction

    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk_i);
            if (data_rvalid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rvalid", data_rvalid_o, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("response", {data_err_o, data_rdata_o}, e);
                end
            end
        end
    end

    initial begin
        idle_inputs();
        rst_ni = 1'b1;
        #2 rst_ni = 1'b0;
        cur = '{we: 1'b0, be: 4'hF, addr: 32'h1000_0010, wdata: 32'h0};
        drive_req(cur);
        @(negedge clk_i);
        chk("reset_outputs", all_outputs(), 128'h0);

        // Single read with minimum latency, granted in the first cycle out of reset.
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("first_gnt", data_gnt_o, 1'b1);
        expect_push(1'b0, 32'hDEADBEEF, 2'b00);
        tick();
        data_req_i = 1'b0;
        @(negedge clk_i);
        chk("rd_cmd", {avm_read_o, avm_write_o, avm_address_o, avm_byteenable_o}, {1'b1, 1'b0, 32'h1000_0010, 4'hF});
        tick();
        avm_readdatavalid_i = 1'b1; avm_readdata_i = 32'hDEADBEEF; avm_response_i = 2'b00;
        @(negedge clk_i);
        chk("rd_not_early", data_rvalid_o, 1'b0);
        tick();
        avm_readdatavalid_i = 1'b0; avm_readdata_i = $urandom;
        @(negedge clk_i);
        chk("rd_latency", data_rvalid_o, 1'b1);
        tick();

        // Outstanding limit: third read waits for the first response.
        d1 = $urandom; d2 = $urandom; d3 = $urandom;
        cur = '{we: 1'b0, be: 4'hF, addr: 32'h2000, wdata: 32'h0};
        drive_req(cur);
        @(negedge clk_i);
        chk("b2b_gnt0", data_gnt_o, 1'b1);
        expect_push(1'b0, d1, 2'b00);
        tick();
        cur.addr = 32'h2004; drive_req(cur);
        @(negedge clk_i);
        chk("b2b_gnt1", data_gnt_o, 1'b1);
        expect_push(1'b0, d2, 2'b01);
        tick();
        cur.addr = 32'h2008; drive_req(cur);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("gnt_blocked", data_gnt_o, 1'b0);
            tick();
        end
        avm_readdatavalid_i = 1'b1; avm_readdata_i = d1; avm_response_i = 2'b00;
        @(negedge clk_i);
        chk("gnt_on_pop", data_gnt_o, 1'b1);
        expect_push(1'b0, d3, 2'b00);
        tick();
        data_req_i = 1'b0;
        avm_readdata_i = d2; avm_response_i = 2'b01;
        @(negedge clk_i);
        chk("third_cmd", {avm_read_o, avm_address_o}, {1'b1, 32'h2008});
        tick();
        avm_readdata_i = d3; avm_response_i = 2'b00;
        tick();
        idle_inputs();
        tick(); tick();

        // Write held by waitrequest for three cycles.
        wd = $urandom;
        cur = '{we: 1'b1, be: 4'b0110, addr: 32'h3000, wdata: wd};
        drive_req(cur);
        @(negedge clk_i);
        chk("wr_gnt", data_gnt_o, 1'b1);
        expect_push(1'b1, 32'h0, 2'b10);
        tick();
        data_req_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            avm_waitrequest_i = (k < 3);
            @(negedge clk_i);
            chk("wr_hold", {avm_write_o, avm_read_o, avm_address_o, avm_byteenable_o, avm_writedata_o},
                {1'b1, 1'b0, 32'h3000, 4'b0110, wd});
            chk("wr_no_early_rvalid", data_rvalid_o, 1'b0);
            tick();
        end
`ifdef IBEX_AVL_WRESP_EN
        avm_writeresponsevalid_i = 1'b1; avm_response_i = 2'b10;
        @(negedge clk_i);
        chk("wr_wait_resp", data_rvalid_o, 1'b0);
        tick();
        avm_writeresponsevalid_i = 1'b0; avm_response_i = 2'b00;
`endif
        @(negedge clk_i);
        chk("wr_complete", {data_rvalid_o, avm_write_o}, {1'b1, 1'b0});
        tick(); tick();

        // Stray write response, then stray read data with nothing outstanding.
        avm_writeresponsevalid_i = 1'b1;
        tick();
        avm_writeresponsevalid_i = 1'b0;
        @(negedge clk_i);
        chk("stray_wresp", protocol_err_o, WrespEn);
        tick();
        avm_readdatavalid_i = 1'b1; avm_readdata_i = $urandom;
        tick();
        avm_readdatavalid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("perr_sticky", {protocol_err_o, data_rvalid_o}, {1'b1, 1'b0});
            tick();
        end
        rst_ni = 1'b0;
        exp_q.delete();
        @(negedge clk_i);
        chk("perr_reset", all_outputs(), 128'h0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Reset with a read outstanding; its late data must be flagged, not returned.
        cur = '{we: 1'b0, be: 4'hF, addr: 32'h4000, wdata: 32'h0};
        drive_req(cur);
        @(negedge clk_i);
        chk("abandon_gnt", data_gnt_o, 1'b1);
        expect_push(1'b0, 32'h0, 2'b00);
        tick();
        data_req_i = 1'b0;
        tick();
        rst_ni = 1'b0;
        data_req_i = 1'b1;
        exp_q.delete();
        @(negedge clk_i);
        chk("rst_mid_outputs", all_outputs(), 128'h0);
        tick(); tick();
        rst_ni = 1'b1;
        data_req_i = 1'b0;
        tick();
        avm_readdatavalid_i = 1'b1; avm_readdata_i = 32'hA5A5_5A5A;
        tick();
        avm_readdatavalid_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            chk("abandon_rsp", {protocol_err_o, data_rvalid_o}, {1'b1, 1'b0});
            tick();
        end
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        idle_inputs();
        tick();

        // Random traffic against the scoreboard and a randomized in-order Avalon slave.
        cyc = 32'd0;
        granted = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            granted = data_req_i && data_gnt_o;
            if (granted) begin
                cmd_q.push_back(cur);
                p.data = $urandom;
                p.resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                plan_q.push_back(p);
                expect_push(cur.we, p.data, p.resp);
            end
            if ((avm_read_o || avm_write_o) && !avm_waitrequest_i) begin
                if (cmd_q.size() == 0) begin
                    chk("cmd_unexpected", {avm_read_o, avm_write_o}, 2'b00);
                end else begin
                    c = cmd_q.pop_front();
                    p = plan_q.pop_front();
                    chk("cmd_match",
                        {avm_write_o, avm_read_o, avm_byteenable_o, avm_address_o, avm_write_o ? avm_writedata_o : 32'h0},
                        {c.we, ~c.we, c.be, c.addr, c.we ? c.wdata : 32'h0});
                    if (!c.we || WrespEn)
                        pend_q.push_back('{we: c.we, data: p.data, resp: p.resp, ready: cyc + 1 + $urandom_range(0, 3)});
                end
            end
            tick();
            cyc++;
            if (!data_req_i || granted) begin
                if (i < 2700 && $urandom_range(0, 9) < 6) begin
                    cur.we    = 1'($urandom_range(0, 1));
                    cur.be    = 4'($urandom_range(1, 15));
                    cur.addr  = $urandom & 32'hFFFF_FFFC;
                    cur.wdata = $urandom;
                    drive_req(cur);
                end else begin
                    data_req_i = 1'b0;
                end
            end
            avm_waitrequest_i = ($urandom_range(0, 9) < 3);
            avm_readdatavalid_i = 1'b0;
            avm_writeresponsevalid_i = 1'b0;
            avm_readdata_i = $urandom;
            avm_response_i = 2'($urandom_range(0, 3));
            if (pend_q.size() != 0 && pend_q[0].ready <= cyc) begin
                pe = pend_q.pop_front();
                avm_readdata_i = pe.data;
                avm_response_i = pe.resp;
                if (pe.we) avm_writeresponsevalid_i = 1'b1;
                else       avm_readdatavalid_i = 1'b1;
            end
        end
        @(negedge clk_i);
        chk("drain_exp", exp_q.size(), 0);
        chk("drain_cmd", cmd_q.size(), 0);
        chk("random_perr", protocol_err_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ibex_avalon_bridge.md
IBEX_AVALON_BRIDGE -- requirements
Module: ibex_avalon_bridge

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, legal 1..4: maximum accepted-but-uncompleted transactions.
REQ-002 SHALL have ports clk_i (in, 1, single clock) and rst_ni (in, 1); reset is asynchronous and active-low.
REQ-003 SHALL have core-side ports: data_req_i (in, 1), data_gnt_o (out, 1), data_rvalid_o (out, 1), data_we_i (in, 1), data_be_i (in, 4), data_addr_i (in, 32), data_wdata_i (in, 32), data_rdata_o (out, 32), data_err_o (out, 1).
REQ-004 SHALL have Avalon-MM master ports: avm_read_o (out, 1), avm_write_o (out, 1), avm_address_o (out, 32), avm_byteenable_o (out, 4), avm_writedata_o (out, 32), avm_waitrequest_i (in, 1), avm_readdata_i (in, 32), avm_readdatavalid_i (in, 1), avm_response_i (in, 2), avm_writeresponsevalid_i (in, 1).
REQ-005 SHALL have protocol_err_o (out, 1): sticky flag for an unexpected Avalon response.

Function
REQ-006 Outstanding count SHALL equal the command-slot occupancy (0/1) plus the order-FIFO occupancy (0..MaxOutstanding).
REQ-007 data_gnt_o SHALL be asserted when all hold: data_req_i=1; the command slot is empty or is being accepted by Avalon this cycle; and the outstanding count after this cycle's pops is < MaxOutstanding.
REQ-008 On grant, the command slot SHALL load we/be/addr/wdata and drive avm_read_o=~we or avm_write_o=we from the next cycle.
REQ-009 avm_* command outputs SHALL hold stable while avm_waitrequest_i=1.
REQ-010 Avalon acceptance (command asserted and avm_waitrequest_i=0) SHALL free the slot and push one FIFO entry (1=write, 0=read).
REQ-011 A back-to-back grant in the acceptance cycle SHALL reload the slot with no bubble.
REQ-012 When avm_readdatavalid_i=1 and the FIFO head is a read, the head SHALL pop. Next cycle: data_rvalid_o=1, data_rdata_o=avm_readdata_i, data_err_o=(avm_response_i!=2'b00).
REQ-013 Write completion SHALL follow REQ-024/REQ-025. Completion cycle: data_rvalid_o=1, data_rdata_o=0.
REQ-014 Responses SHALL be returned in issue order; at most one FIFO pop per cycle.
REQ-015 In these cases the response SHALL be dropped and protocol_err_o set until reset:
  - avm_readdatavalid_i with an empty FIFO or a write at the head;
  - avm_writeresponsevalid_i with an empty FIFO or a read at the head;
  - both valid in the same cycle; the head-matching one is still consumed.
REQ-016 A push and a pop in the same cycle SHALL leave FIFO occupancy unchanged; FIFO pointers SHALL wrap modulo MaxOutstanding.
REQ-017 data_rvalid_o SHALL be a single-cycle pulse per completion; data_rdata_o/data_err_o are don't-care when data_rvalid_o=0.
REQ-018 Minimum read latency SHALL be 3 cycles from grant (cycle N):
  - N+1: command presented;
  - N+2: earliest readdatavalid;
  - N+3: data_rvalid_o.

Reset
REQ-019 While rst_ni=0, the following SHALL be 0: data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o, avm_read_o, avm_write_o, avm_address_o, avm_byteenable_o, avm_writedata_o, protocol_err_o.
REQ-020 Reset SHALL empty the command slot and the order FIFO; count=0.
REQ-021 Reset asserted mid-transaction SHALL abandon all in-flight transactions.
REQ-022 After reset release, Avalon responses to abandoned transactions SHALL be treated per REQ-015.
REQ-023 The first grant SHALL be possible in the first cycle with rst_ni=1.

Configuration
REQ-024 With macro IBEX_AVL_WRESP_EN defined: a write-head FIFO entry SHALL pop only on avm_writeresponsevalid_i; data_err_o=(avm_response_i!=2'b00).
REQ-025 Without IBEX_AVL_WRESP_EN:
  - a write-head entry SHALL pop in the cycle it reaches the head, with data_err_o=0;
  - avm_writeresponsevalid_i SHALL be ignored and SHALL NOT set protocol_err_o.

Verification
REQ-026 Read, waitrequest=0, readdata=32'hDEADBEEF at N+2, response=00 -> avm_read_o at N+1; data_rvalid_o at N+3 with rdata=32'hDEADBEEF, err=0.
REQ-027 Two reads granted back-to-back, MaxOutstanding=2, no responses -> third request not granted until the first readdatavalid; responses returned in order.
REQ-028 Write with waitrequest=1 for 3 cycles -> avm_write_o, address, byteenable and writedata stable 4 cycles; one FIFO push.
REQ-029 WRESP_EN defined, write then writeresponsevalid with response=2'b10 -> data_rvalid_o=1, data_err_o=1. Without WRESP_EN -> rvalid one cycle after write acceptance, err=0.
REQ-030 readdatavalid with an empty FIFO -> no data_rvalid_o; protocol_err_o=1 until rst_ni=0.
REQ-031 rst_ni=0 with one read outstanding, release, then readdatavalid -> all outputs 0 during reset; no rvalid; protocol_err_o=1.
